// File: rtl/twiddle_sched_pkg.sv
// Shared types and default widths for the twiddle ROM burst scheduler.
package twiddle_sched_pkg;
  localparam int ADDR_WIDTH_D  = 9;
  localparam int DATA_WIDTH_D  = 16;
  localparam int STAGE_WIDTH_D = 4;
  localparam int CID_WIDTH     = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/twiddle_addr_gen.sv
// Stage-strided address generator: latches a burst's stage and length on load,
// then steps the ROM address once per issue and flags the final address.
module twiddle_addr_gen
  import twiddle_sched_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_D,
  parameter int STAGE_WIDTH = STAGE_WIDTH_D
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   issue,
  input  logic [STAGE_WIDTH-1:0] stage,
  input  logic [ADDR_WIDTH:0]    len,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic                   last_issue
);
  localparam logic [ADDR_WIDTH:0]   K_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] stride;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] acc;
  logic [ADDR_WIDTH:0]   k;
  logic [ADDR_WIDTH:0]   len_q;

  // Strides at or beyond the address width alias to 0 modulo DEPTH.
  assign stride     = (int'(stage) < ADDR_WIDTH) ? (A_ONE << stage) : '0;
  assign last_issue = (k == len_q - K_ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stride_q <= '0;
      acc      <= '0;
      k        <= '0;
      len_q    <= '0;
      addr     <= '0;
    end else if (load) begin
      stride_q <= stride;
      acc      <= '0;
      k        <= '0;
      len_q    <= len;
    end else if (issue) begin
      addr <= acc;
      acc  <= acc + stride_q;
      k    <= k + K_ONE;
    end
  end
endmodule

// File: rtl/twiddle_rom_sched.sv
// Round-robin burst scheduler sharing one registered-read twiddle ROM between
// the FFT (client 0) and IFFT (client 1) engines, with a tagged return pipe.
//
// state | meaning
// IDLE  | sample requests, grant round-robin, latch stage/len
// ISSUE | one ROM address per enabled cycle until len addresses issued
// DRAIN | wait for the return pipe to empty (or emit a zero-length done)
module twiddle_rom_sched
  import twiddle_sched_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_D,
  parameter int DATA_WIDTH  = DATA_WIDTH_D,
  parameter int STAGE_WIDTH = STAGE_WIDTH_D
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   c0_req,
  input  logic                   c1_req,
  input  logic [STAGE_WIDTH-1:0] c0_stage,
  input  logic [STAGE_WIDTH-1:0] c1_stage,
  input  logic [ADDR_WIDTH:0]    c0_len,
  input  logic [ADDR_WIDTH:0]    c1_len,
  output logic                   c0_ack,
  output logic                   c1_ack,
  output logic                   c0_done,
  output logic                   c1_done,
  input  logic                   en,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  output logic                   rom_clk_en,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  output logic [DATA_WIDTH-1:0]  tw_data,
  output logic                   tw_valid,
  output logic [CID_WIDTH-1:0]   tw_client,
  output logic                   tw_last
);
  state_t                 state;
  logic [CID_WIDTH-1:0]   last_served;
  logic [CID_WIDTH-1:0]   owner;
  logic [CID_WIDTH-1:0]   pick;
  logic [STAGE_WIDTH-1:0] sel_stage;
  logic [ADDR_WIDTH:0]    sel_len;
  logic                   load;
  logic                   issue;
  logic                   last_issue;
  logic                   zero_pend;
  logic                   p1_valid;
  logic                   p1_last;
  logic                   p1_zero;
  logic [CID_WIDTH-1:0]   p1_client;

  // Contention goes to whoever was not served last; a lone requester always wins.
  assign pick      = (c0_req && c1_req) ? ~last_served : CID_WIDTH'(c1_req);
  assign sel_stage = pick[0] ? c1_stage : c0_stage;
  assign sel_len   = pick[0] ? c1_len : c0_len;
  assign load      = (state == IDLE) && (c0_req || c1_req);
  assign issue     = (state == ISSUE) && en;

  assign tw_data    = rom_data;
  assign rom_clk_en = (state != IDLE) || p1_valid || p1_zero || tw_valid;

  twiddle_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STAGE_WIDTH (STAGE_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .issue      (issue),
    .stage      (sel_stage),
    .len        (sel_len),
    .addr       (rom_addr),
    .last_issue (last_issue)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_served <= CID_WIDTH'(1);
      owner       <= '0;
      zero_pend   <= 1'b0;
      c0_ack      <= 1'b0;
      c1_ack      <= 1'b0;
      p1_valid    <= 1'b0;
      p1_last     <= 1'b0;
      p1_zero     <= 1'b0;
      p1_client   <= '0;
      tw_valid    <= 1'b0;
      tw_last     <= 1'b0;
      tw_client   <= '0;
      c0_done     <= 1'b0;
      c1_done     <= 1'b0;
    end else begin
      c0_ack   <= 1'b0;
      c1_ack   <= 1'b0;
      p1_valid <= issue;
      p1_last  <= issue && last_issue;
      p1_zero  <= 1'b0;
      if (issue) p1_client <= owner;

      case (state)
        IDLE: begin
          if (c0_req || c1_req) begin
            owner       <= pick;
            last_served <= pick;
            c0_ack      <= ~pick[0];
            c1_ack      <= pick[0];
            if (sel_len == '0) begin
              state     <= DRAIN;
              zero_pend <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (en && last_issue) state <= DRAIN;
        end
        DRAIN: begin
          // A zero-length burst sends a data-less token down the pipe to carry its done.
          if (zero_pend) begin
            zero_pend <= 1'b0;
            p1_zero   <= 1'b1;
            p1_client <= owner;
          end else if (!p1_valid && !p1_zero) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      tw_valid <= p1_valid;
      tw_last  <= p1_valid && p1_last;
      if (p1_valid || p1_zero) tw_client <= p1_client;
      c0_done  <= ((p1_valid && p1_last) || p1_zero) && !p1_client[0];
      c1_done  <= ((p1_valid && p1_last) || p1_zero) && p1_client[0];
    end
  end
endmodule

// File: tb/tb_twiddle_rom_sched.sv
// Directed bench for twiddle_rom_sched: strided bursts, stalls, zero length,
// round-robin arbitration and asynchronous reset.
module tb_twiddle_rom_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c0_req = 1'b0, c1_req = 1'b0;
  logic [3:0]  c0_stage = '0, c1_stage = '0;
  logic [9:0]  c0_len = '0, c1_len = '0;
  logic        c0_ack, c1_ack, c0_done, c1_done;
  logic        en = 1'b1;
  logic [8:0]  rom_addr;
  logic        rom_clk_en;
  logic [15:0] rom_data = '0;
  logic [15:0] tw_data;
  logic        tw_valid;
  logic [0:0]  tw_client;
  logic        tw_last;

  int checks = 0;
  int failures = 0;

  twiddle_rom_sched dut (
    .clk        (clk),
    .rst        (rst),
    .c0_req     (c0_req),
    .c1_req     (c1_req),
    .c0_stage   (c0_stage),
    .c1_stage   (c1_stage),
    .c0_len     (c0_len),
    .c1_len     (c1_len),
    .c0_ack     (c0_ack),
    .c1_ack     (c1_ack),
    .c0_done    (c0_done),
    .c1_done    (c1_done),
    .en         (en),
    .rom_addr   (rom_addr),
    .rom_clk_en (rom_clk_en),
    .rom_data   (rom_data),
    .tw_data    (tw_data),
    .tw_valid   (tw_valid),
    .tw_client  (tw_client),
    .tw_last    (tw_last)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [8:0] a);
    return 16'h0100 + 16'(a) * 16'd37;
  endfunction

  always @(posedge clk) rom_data <= mem_val(rom_addr);

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rom_addr !== 9'd0) begin
      failures++;
      $display("FAIL reset rom_addr got=%0d exp=0", rom_addr);
    end
    checks++;
    if ({c0_ack, c1_ack, c0_done, c1_done, tw_valid, tw_last, tw_client, rom_clk_en} !== 8'b0) begin
      failures++;
      $display("FAIL reset flags got=%b exp=00000000",
               {c0_ack, c1_ack, c0_done, c1_done, tw_valid, tw_last, tw_client, rom_clk_en});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_burst(input string name, input logic cl, input logic [3:0] stg, input int n);
    logic [8:0] stride;
    logic [8:0] exp_a;
    int k;
    stride = (int'(stg) < 9) ? (9'd1 << stg) : 9'd0;
    if (cl) begin c1_req = 1'b1; c1_stage = stg; c1_len = 10'(n); end
    else    begin c0_req = 1'b1; c0_stage = stg; c0_len = 10'(n); end
    @(posedge clk);
    @(negedge clk);
    c0_req = 1'b0;
    c1_req = 1'b0;
    for (int rel = 1; rel <= n + 3; rel++) begin
      if (rel > 1) @(negedge clk);
      checks++;
      if ({c0_ack, c1_ack} !== {(rel == 1) && !cl, (rel == 1) && cl}) begin
        failures++;
        $display("FAIL %s ack rel=%0d got=%b", name, rel, {c0_ack, c1_ack});
      end
      checks++;
      if ({c0_done, c1_done} !== {(rel == n + 2) && !cl, (rel == n + 2) && cl}) begin
        failures++;
        $display("FAIL %s done rel=%0d got=%b", name, rel, {c0_done, c1_done});
      end
      checks++;
      if (tw_valid !== (rel >= 3 && rel <= n + 2)) begin
        failures++;
        $display("FAIL %s tw_valid rel=%0d got=%b", name, rel, tw_valid);
      end
      if (rel >= 3 && rel <= n + 2) begin
        k = rel - 3;
        exp_a = 9'(k * int'(stride));
        checks++;
        if ({tw_data, tw_client, tw_last} !== {mem_val(exp_a), cl, k == n - 1}) begin
          failures++;
          $display("FAIL %s beat k=%0d got data=%h cl=%b last=%b exp data=%h cl=%b last=%b",
                   name, k, tw_data, tw_client, tw_last, mem_val(exp_a), cl, k == n - 1);
        end
      end
      if (rel >= 2 && rel <= n + 1) begin
        k = rel - 2;
        exp_a = 9'(k * int'(stride));
        checks++;
        if (rom_addr !== exp_a) begin
          failures++;
          $display("FAIL %s rom_addr k=%0d got=%0d exp=%0d", name, k, rom_addr, exp_a);
        end
      end
      checks++;
      if (rom_clk_en !== (rel <= n + 2)) begin
        failures++;
        $display("FAIL %s rom_clk_en rel=%0d got=%b", name, rel, rom_clk_en);
      end
    end
  endtask

  task automatic test_stall;
    int vk[12] = '{-1, -1, -1, 0, 1, -1, -1, 2, 3, 4, 5, -1};
    int ak[12] = '{-1, -1, 0, 1, 1, 1, 2, 3, 4, 5, -1, -1};
    c0_req = 1'b1; c0_stage = 4'd1; c0_len = 10'd6;
    @(posedge clk);
    @(negedge clk);
    c0_req = 1'b0;
    for (int rel = 1; rel <= 11; rel++) begin
      if (rel > 1) @(negedge clk);
      checks++;
      if (tw_valid !== (vk[rel] >= 0)) begin
        failures++;
        $display("FAIL stall tw_valid rel=%0d got=%b exp=%b", rel, tw_valid, vk[rel] >= 0);
      end
      if (vk[rel] >= 0) begin
        checks++;
        if ({tw_data, tw_last} !== {mem_val(9'(2 * vk[rel])), vk[rel] == 5}) begin
          failures++;
          $display("FAIL stall beat rel=%0d got data=%h last=%b exp data=%h",
                   rel, tw_data, tw_last, mem_val(9'(2 * vk[rel])));
        end
      end
      if (ak[rel] >= 0) begin
        checks++;
        if (rom_addr !== 9'(2 * ak[rel])) begin
          failures++;
          $display("FAIL stall rom_addr rel=%0d got=%0d exp=%0d", rel, rom_addr, 2 * ak[rel]);
        end
      end
      checks++;
      if (c0_done !== (rel == 10)) begin
        failures++;
        $display("FAIL stall c0_done rel=%0d got=%b", rel, c0_done);
      end
      en = !(rel == 3 || rel == 4);
    end
    en = 1'b1;
    checks++;
    if (rom_clk_en !== 1'b0) begin
      failures++;
      $display("FAIL stall idle rom_clk_en got=%b exp=0", rom_clk_en);
    end
  endtask

  task automatic test_zero_len;
    c1_req = 1'b1; c1_stage = 4'd0; c1_len = 10'd0;
    @(posedge clk);
    @(negedge clk);
    c1_req = 1'b0;
    checks++;
    if ({c0_ack, c1_ack} !== 2'b01) begin
      failures++;
      $display("FAIL zero_len ack got=%b exp=01", {c0_ack, c1_ack});
    end
    for (int rel = 1; rel <= 4; rel++) begin
      if (rel > 1) @(negedge clk);
      checks++;
      if ({tw_valid, c0_done, c1_done} !== {1'b0, 1'b0, rel == 3}) begin
        failures++;
        $display("FAIL zero_len rel=%0d valid/done0/done1 got=%b exp=00%b",
                 rel, {tw_valid, c0_done, c1_done}, rel == 3);
      end
    end
  endtask

  task automatic test_round_robin;
    int n_ack = 0;
    int who[4];
    int when[4];
    int lens[2] = '{2, 3};
    logic both = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    c0_req = 1'b1; c0_stage = 4'd0; c0_len = 10'd2;
    c1_req = 1'b1; c1_stage = 4'd2; c1_len = 10'd3;
    for (int cyc = 0; cyc < 80 && n_ack < 4; cyc++) begin
      @(negedge clk);
      if (c0_ack && c1_ack) both = 1'b1;
      if (c0_ack || c1_ack) begin
        who[n_ack] = c1_ack ? 1 : 0;
        when[n_ack] = cyc;
        n_ack++;
      end
    end
    c0_req = 1'b0;
    c1_req = 1'b0;
    checks++;
    if (n_ack != 4 || both) begin
      failures++;
      $display("FAIL rr ack_count got=%0d both=%b exp=4 both=0", n_ack, both);
    end
    for (int i = 0; i < n_ack; i++) begin
      checks++;
      if (who[i] != i % 2) begin
        failures++;
        $display("FAIL rr order i=%0d got=%0d exp=%0d", i, who[i], i % 2);
      end
      if (i > 0) begin
        checks++;
        if (when[i] - when[i-1] < lens[who[i-1]] + 3) begin
          failures++;
          $display("FAIL rr gap i=%0d got=%0d exp>=%0d", i, when[i] - when[i-1], lens[who[i-1]] + 3);
        end
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    c0_req = 1'b1; c0_stage = 4'd0; c0_len = 10'd8;
    @(posedge clk);
    @(negedge clk);
    c0_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tw_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid pre tw_valid got=%b exp=1", tw_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rom_addr !== 9'd0) begin
      failures++;
      $display("FAIL rst_mid rom_addr got=%0d exp=0", rom_addr);
    end
    checks++;
    if ({c0_ack, c1_ack, c0_done, c1_done, tw_valid, tw_last, tw_client, rom_clk_en} !== 8'b0) begin
      failures++;
      $display("FAIL rst_mid flags got=%b exp=00000000",
               {c0_ack, c1_ack, c0_done, c1_done, tw_valid, tw_last, tw_client, rom_clk_en});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (c0_done || c1_done || tw_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid abandoned burst activity got=1 exp=0");
    end
    c0_req = 1'b1; c0_len = 10'd1;
    c1_req = 1'b1; c1_len = 10'd1;
    @(posedge clk);
    @(negedge clk);
    c0_req = 1'b0;
    c1_req = 1'b0;
    checks++;
    if ({c0_ack, c1_ack} !== 2'b10) begin
      failures++;
      $display("FAIL rst_mid post-reset winner got=%b exp=10", {c0_ack, c1_ack});
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_burst("c0_s0_len4", 1'b0, 4'd0, 4);
    test_burst("c1_s3_len3", 1'b1, 4'd3, 3);
    test_burst("c0_s8_len4", 1'b0, 4'd8, 4);
    test_burst("c1_s10_len4", 1'b1, 4'd10, 4);
    test_stall();
    test_zero_len();
    test_round_robin();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
